// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
//   Single-cycle ops (AND/OR/ADD/SUB/NOR/SLT/SLTU/XOR) complete at the accept
//   edge. MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring
//   divider, both one bit per cycle, with a final sign-fix cycle.
// Optional feature macro: ALU_MC_DIV_EN (divider present when defined; when
//   undefined, opcodes 1000/1001 are treated as undefined opcodes).
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   ALU_IN_1/ALU_IN_2   operands A/B, sampled on in_valid & in_ready
//   ALU_control         4-bit operation code
//   in_valid/in_ready   request handshake; in_ready high only when IDLE
//   out_valid           one-cycle pulse when results are updated
//   ALU_result/ALU_hi   LO and HI results (HI = 0 for single-cycle ops)
//   ALU_zero            ALU_result == 0, registered with ALU_result
//   ALU_ovf/ALU_dz      signed ADD/SUB overflow, divide-by-zero
//   ALU_illegal         undefined opcode
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] ALU_IN_1,
  input  logic [WIDTH-1:0] ALU_IN_2,
  input  logic [3:0]       ALU_control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] ALU_hi,
  output logic             ALU_zero,
  output logic             ALU_ovf,
  output logic             ALU_dz,
  output logic             ALU_illegal
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   lo_q;   // multiplier -> product LO / dividend -> quotient
  logic [WIDTH-1:0]   hi_q;   // product HI / partial remainder
  logic [WIDTH-1:0]   opb_q;  // multiplicand / divisor magnitude
  logic               neg_q;  // operand signs differ (negate product/quotient)

  logic               accept, op_mul, op_div, op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   sum, diff, one_res;
  logic               one_ovf, one_ill;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_lo, fix_hi;

`ifdef ALU_MC_DIV_EN
  logic [WIDTH-1:0]   a_raw_q;
  logic               div_q, dz_q, neg_rem_q;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
`endif

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    op_signed = ALU_control[0];
    op_mul    = (ALU_control == 4'b0100) || (ALU_control == 4'b0101);
`ifdef ALU_MC_DIV_EN
    op_div    = (ALU_control == 4'b1000) || (ALU_control == 4'b1001);
`else
    op_div    = 1'b0;
`endif
    abs_a = (op_signed && ALU_IN_1[WIDTH-1]) ? ('0 - ALU_IN_1) : ALU_IN_1;
    abs_b = (op_signed && ALU_IN_2[WIDTH-1]) ? ('0 - ALU_IN_2) : ALU_IN_2;
  end

  always_comb begin
    sum     = ALU_IN_1 + ALU_IN_2;
    diff    = ALU_IN_1 - ALU_IN_2;
    one_res = '0;
    one_ovf = 1'b0;
    one_ill = 1'b0;
    case (ALU_control)
      4'b0000: one_res = ALU_IN_1 & ALU_IN_2;
      4'b0001: one_res = ALU_IN_1 | ALU_IN_2;
      4'b0010: begin
        one_res = sum;
        one_ovf = (ALU_IN_1[WIDTH-1] == ALU_IN_2[WIDTH-1]) &&
                  (sum[WIDTH-1] != ALU_IN_1[WIDTH-1]);
      end
      4'b0110: begin
        one_res = diff;
        one_ovf = (ALU_IN_1[WIDTH-1] != ALU_IN_2[WIDTH-1]) &&
                  (diff[WIDTH-1] != ALU_IN_1[WIDTH-1]);
      end
      4'b1100: one_res = ~(ALU_IN_1 | ALU_IN_2);
      4'b0111: one_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_IN_1) < $signed(ALU_IN_2))};
      4'b0011: one_res = {{(WIDTH-1){1'b0}}, (ALU_IN_1 < ALU_IN_2)};
      4'b1010: one_res = ALU_IN_1 ^ ALU_IN_2;
      default: one_ill = 1'b1;
    endcase
  end

  // Iteration datapath and final sign correction.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? ('0 - prod) : prod;
    fix_lo   = prod_fix[WIDTH-1:0];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    if (div_q) begin
      if (dz_q) begin
        fix_lo = '1;
        fix_hi = a_raw_q;
      end else begin
        // Remainder follows the dividend sign; quotient negative if signs differ.
        fix_lo = neg_q ? ('0 - lo_q) : lo_q;
        fix_hi = neg_rem_q ? ('0 - hi_q) : hi_q;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && op_mul)      state_nxt = MUL;
        else if (accept && op_div) state_nxt = DIV;
      end
      MUL, DIV: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      opb_q       <= '0;
      neg_q       <= 1'b0;
      out_valid   <= 1'b0;
      ALU_result  <= '0;
      ALU_hi      <= '0;
      ALU_zero    <= 1'b1;
      ALU_ovf     <= 1'b0;
      ALU_dz      <= 1'b0;
      ALU_illegal <= 1'b0;
`ifdef ALU_MC_DIV_EN
      a_raw_q     <= '0;
      div_q       <= 1'b0;
      dz_q        <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_mul || op_div) begin
              lo_q  <= abs_a;
              opb_q <= abs_b;
              hi_q  <= '0;
              cnt   <= '0;
              neg_q <= op_signed && (ALU_IN_1[WIDTH-1] ^ ALU_IN_2[WIDTH-1]);
`ifdef ALU_MC_DIV_EN
              a_raw_q   <= ALU_IN_1;
              div_q     <= op_div;
              dz_q      <= op_div && (ALU_IN_2 == '0);
              neg_rem_q <= op_signed && ALU_IN_1[WIDTH-1];
`endif
            end else begin
              ALU_result  <= one_res;
              ALU_hi      <= '0;
              ALU_zero    <= (one_res == '0);
              ALU_ovf     <= one_ovf;
              ALU_dz      <= 1'b0;
              ALU_illegal <= one_ill;
              out_valid   <= 1'b1;
            end
          end
        end
        MUL: begin
          // Add-then-shift: HI absorbs the carry, LO shifts out used multiplier bits.
          hi_q <= mul_sum[WIDTH:1];
          lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          hi_q <= div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], div_ge};
          cnt  <= cnt + CNT_W'(1);
        end
`endif
        FIX: begin
          ALU_result  <= fix_lo;
          ALU_hi      <= fix_hi;
          ALU_zero    <= (fix_lo == '0);
          ALU_ovf     <= 1'b0;
          ALU_illegal <= 1'b0;
`ifdef ALU_MC_DIV_EN
          ALU_dz      <= div_q && dz_q;
`else
          ALU_dz      <= 1'b0;
`endif
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
